// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone RAM arbiter.
package wb_arb_pkg;

   // Arbiter ownership state; the encoding is also the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } arb_state_t;

   // Wishbone B3 cycle type identifiers.
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts owner strobe cycles without a slave termination and
// fires a single-cycle pulse when the count reaches TIMEOUT.
module wb_arb_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic stb,
   input  logic term,
   output logic fire
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

   logic [TO_W-1:0] count;
   logic            armed;

   // A cycle only counts while someone owns the bus, strobes, and gets no reply.
   assign armed = active && stb && !term;
   assign fire  = (TIMEOUT > 0) && armed && (count == LIMIT);

   // Count stalled strobe cycles; restart after any break or after firing.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (!armed || fire || (TIMEOUT == 0)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master to one-slave Wishbone B3 arbiter for the RAM port.
// Master 0 is the instruction bus, master 1 the data bus. Ownership lasts for
// the whole cyc so bursts are never split; a watchdog ends hung accesses.
module wb_mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   // master 0 (instruction)
   input  logic [AW-1:0]   wbm0_adr_i,
   input  logic [DW-1:0]   wbm0_dat_i,
   input  logic [DW/8-1:0] wbm0_sel_i,
   input  logic            wbm0_we_i,
   input  logic            wbm0_cyc_i,
   input  logic            wbm0_stb_i,
   input  logic [2:0]      wbm0_cti_i,
   input  logic [1:0]      wbm0_bte_i,
   output logic [DW-1:0]   wbm0_rdt_o,
   output logic            wbm0_ack_o,
   output logic            wbm0_err_o,
   output logic            wbm0_rty_o,
   // master 1 (data)
   input  logic [AW-1:0]   wbm1_adr_i,
   input  logic [DW-1:0]   wbm1_dat_i,
   input  logic [DW/8-1:0] wbm1_sel_i,
   input  logic            wbm1_we_i,
   input  logic            wbm1_cyc_i,
   input  logic            wbm1_stb_i,
   input  logic [2:0]      wbm1_cti_i,
   input  logic [1:0]      wbm1_bte_i,
   output logic [DW-1:0]   wbm1_rdt_o,
   output logic            wbm1_ack_o,
   output logic            wbm1_err_o,
   output logic            wbm1_rty_o,
   // slave
   output logic [AW-1:0]   wbs_adr_o,
   output logic [DW-1:0]   wbs_dat_o,
   output logic [DW/8-1:0] wbs_sel_o,
   output logic            wbs_we_o,
   output logic            wbs_cyc_o,
   output logic            wbs_stb_o,
   output logic [2:0]      wbs_cti_o,
   output logic [1:0]      wbs_bte_o,
   input  logic [DW-1:0]   wbs_rdt_i,
   input  logic            wbs_ack_i,
   input  logic            wbs_err_i,
   input  logic            wbs_rty_i,
   // status
   output logic [1:0]      grant_o,
   output logic            timeout_o
);

   import wb_arb_pkg::*;

   arb_state_t state;
   arb_state_t state_next;
   logic       last_owner;
   logic       last_owner_next;
   logic       owner_stb;
   logic       slave_term;
   logic       fire;

   assign grant_o    = state;
   assign timeout_o  = fire;
   assign wbm0_rdt_o = wbs_rdt_i;
   assign wbm1_rdt_o = wbs_rdt_i;
   assign slave_term = wbs_ack_i || wbs_err_i || wbs_rty_i;
   assign owner_stb  = (state == OWN0) ? wbm0_stb_i :
                       (state == OWN1) ? wbm1_stb_i : 1'b0;

   wb_arb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_watchdog (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .active (state != IDLE),
      .stb    (owner_stb),
      .term   (slave_term),
      .fire   (fire)
   );

   // Ownership register and round-robin history.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state      <= state_next;
         last_owner <= last_owner_next;
      end
   end

   // Arbitration decisions plus the request/response steering for the owner.
   always_comb begin
      state_next      = state;
      last_owner_next = last_owner;
      wbs_adr_o       = '0;
      wbs_dat_o       = '0;
      wbs_sel_o       = '0;
      wbs_we_o        = 1'b0;
      wbs_cyc_o       = 1'b0;
      wbs_stb_o       = 1'b0;
      wbs_cti_o       = '0;
      wbs_bte_o       = '0;
      wbm0_ack_o      = 1'b0;
      wbm0_err_o      = 1'b0;
      wbm0_rty_o      = 1'b0;
      wbm1_ack_o      = 1'b0;
      wbm1_err_o      = 1'b0;
      wbm1_rty_o      = 1'b0;
      case (state)
         IDLE: begin
            if (wbm0_cyc_i && wbm1_cyc_i) begin
               state_next = last_owner ? OWN0 : OWN1;
            end else if (wbm0_cyc_i) begin
               state_next = OWN0;
            end else if (wbm1_cyc_i) begin
               state_next = OWN1;
            end
         end
         OWN0: begin
            wbs_adr_o  = wbm0_adr_i;
            wbs_dat_o  = wbm0_dat_i;
            wbs_sel_o  = wbm0_sel_i;
            wbs_we_o   = wbm0_we_i;
            wbs_cyc_o  = wbm0_cyc_i;
            wbs_stb_o  = wbm0_stb_i && !fire;
            wbs_cti_o  = wbm0_cti_i;
            wbs_bte_o  = wbm0_bte_i;
            wbm0_ack_o = wbs_ack_i;
            wbm0_err_o = wbs_err_i || fire;
            wbm0_rty_o = wbs_rty_i;
            if (!wbm0_cyc_i) begin
               state_next      = IDLE;
               last_owner_next = 1'b0;
            end
         end
         OWN1: begin
            wbs_adr_o  = wbm1_adr_i;
            wbs_dat_o  = wbm1_dat_i;
            wbs_sel_o  = wbm1_sel_i;
            wbs_we_o   = wbm1_we_i;
            wbs_cyc_o  = wbm1_cyc_i;
            wbs_stb_o  = wbm1_stb_i && !fire;
            wbs_cti_o  = wbm1_cti_i;
            wbs_bte_o  = wbm1_bte_i;
            wbm1_ack_o = wbs_ack_i;
            wbm1_err_o = wbs_err_i || fire;
            wbm1_rty_o = wbs_rty_i;
            if (!wbm1_cyc_i) begin
               state_next      = IDLE;
               last_owner_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master to one-slave Wishbone B3 arbiter. It shares the main RAM port between the OR1200 instruction bus (master 0) and data bus (master 1).
- Sits between the interconnect's master ports and ram_wb_b3.
- Grants round-robin and holds the grant for the whole cycle (cyc), so incrementing bursts are never split.
- Contains a bus watchdog that terminates hung accesses with err.

Parameters:
- AW, 32, address width
- DW, 32, data width (sel width is DW/8)
- TIMEOUT, 255, cycles with stb high and no ack/err/rty before watchdog err; 0 disables the watchdog
- TO_W, 8, watchdog counter width; must satisfy 2**TO_W > TIMEOUT

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbm0_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  AW/DW/DW/8/1/1/1/3/2  master 0 (instruction) request
- wbm0_rdt_o/ack_o/err_o/rty_o  out  DW/1/1/1  master 0 response
- wbm1_* (same set as master 0)  in/out  as master 0  master 1 (data)
- wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  AW/DW/DW/8/1/1/1/3/2  slave request
- wbs_rdt_i/ack_i/err_i/rty_i  in  DW/1/1/1  slave response
- grant_o  out  2  one-hot current owner; 00 = idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- FSM states: IDLE, OWN0, OWN1. The state register is the only owner record. grant_o decodes the state.
- Register last_owner, 1 bit. Reset value 1, so master 0 wins the first tie.
- IDLE:
  - If only mN cyc_i is high, go to OWN_N.
  - If both are high, grant the master that is not last_owner.
  - Request-to-slave latency is 1 cycle: cyc seen at edge N, wbs_cyc_o high after edge N.
- OWN_N:
  - Slave request outputs = master N inputs, combinational mux.
  - wbmN_ack/err/rty_o = wbs_*_i gated by grant. The non-owner sees 0.
  - wbm0_rdt_o = wbm1_rdt_o = wbs_rdt_i, unconditionally.
- Release:
  - When the owner drops cyc_i, the next state is IDLE and last_owner = N.
  - No back-to-back re-grant without passing through IDLE. This gives one idle cycle between owners.
  - A cti=111 end-of-burst with cyc still high does not release.
- In IDLE, all wbs_* outputs are 0 and all master ack/err/rty outputs are 0.
- A waiting master's request is ignored until grant. Its stb may stay high indefinitely.
- Watchdog (only when TIMEOUT > 0):
  - Counter clears whenever the state is IDLE, the owner's stb is low, or any of wbs ack/err/rty is high.
  - Otherwise the counter increments.
  - When the count equals TIMEOUT, in that same cycle: owner err_o = 1, wbs_stb_o forced 0, timeout_o = 1, and the counter clears.
  - Ownership is kept; the master is expected to drop cyc.
  - If slave ack arrives in the firing cycle, ack wins: err is suppressed and timeout_o = 0.
- Slave err/rty are passed through unmodified and do not affect ownership.
- Reset, including mid-transfer:
  - State goes to IDLE, last_owner = 1, counter = 0.
  - Outputs: wbs_cyc_o = wbs_stb_o = 0, all wbs_* = 0, grant_o = 00, timeout_o = 0, all master ack/err/rty = 0.
- Width rules: the counter saturates logically at TIMEOUT via compare. No wrap is reachable given the TO_W constraint.

Decomposition:
- Package wb_arb_pkg:
  - FSM state enum (IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10; state bits double as grant_o).
  - CTI constants (CLASSIC = 000, INC = 010, EOB = 111).
- One natural sub-module: wb_arb_watchdog. It holds the counter, compare and timeout pulse, with inputs active/stb/term and output fire.
- FSM and mux stay in the top.

Test Plan:
- Reset, then m0 single read at 0x100 (cti=000) with slave ack one cycle after stb → grant_o=01 one cycle after cyc; m0 gets ack and the slave rdt (e.g. 0xDEADBEEF); m1 ack stays 0.
- m0 and m1 raise cyc in the same cycle → m0 owns first; after m0 drops cyc, 1 idle cycle, then m1 owns. Repeat the simultaneous request → m0 wins again (round-robin).
- m0 4-beat INC burst (cti 010,010,010,111) while m1 requests from beat 1 → m1 is not granted until m0 drops cyc; all 4 acks go to m0 only.
- TIMEOUT=8, m1 write to a slave that never acks → exactly 8 cycles of stb, then a 1-cycle m1 err plus timeout_o; wbs_stb_o low in that cycle; the counter restarts if stb is held.
- Slave ack coincides with the watchdog fire cycle → m1 sees ack, no err, timeout_o=0.
- Assert wb_rst_i during an m1 burst → after the edge, grant_o=00, wbs_cyc_o=0, no ack/err to either master. Next simultaneous request is granted to m0.
